// File: rtl/sub_modp_serial.sv
// Limb-serial modular subtractor over GF(2^255 - 19): diff = (x - y) mod p,
// one LIMB-bit borrow-chained subtract per clock, with a correction pass on underflow.
module sub_modp_serial #(
  parameter int N    = 255,
  parameter int LIMB = 51
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic [1:0]   fsm_state
);

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid and ready are both 1; ready/valid here are pure decodes of state.

  localparam int K  = N / LIMB;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [IW-1:0]   LAST_IDX  = IW'(K - 1);
  localparam logic [LIMB-1:0] FIX_CONST = LIMB'(19);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          borrow;
  logic [N-1:0]  x_r;
  logic [N-1:0]  y_r;
  logic [N-1:0]  res_r;

  logic [LIMB-1:0] a_limb;
  logic [LIMB-1:0] s_limb;
  logic [LIMB:0]   limb_diff;
  logic            last_limb;

  // SUB consumes the operand limbs; FIX re-walks the result to subtract 19.
  always_comb begin
    a_limb = '0;
    s_limb = '0;
    case (state)
      S_SUB: begin
        a_limb = x_r[int'(idx)*LIMB +: LIMB];
        s_limb = y_r[int'(idx)*LIMB +: LIMB];
      end
      S_FIX: begin
        a_limb = res_r[int'(idx)*LIMB +: LIMB];
        s_limb = (idx == '0) ? FIX_CONST : '0;
      end
      default: begin
        a_limb = '0;
        s_limb = '0;
      end
    endcase
  end

  assign limb_diff = {1'b0, a_limb} - {1'b0, s_limb} - {{LIMB{1'b0}}, borrow};
  assign last_limb = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      borrow <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      res_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_r    <= x;
            y_r    <= y;
            idx    <= '0;
            borrow <= 1'b0;
            state  <= S_SUB;
          end
        end
        S_SUB: begin
          res_r[int'(idx)*LIMB +: LIMB] <= limb_diff[LIMB-1:0];
          if (last_limb) begin
            // A final borrow means the register holds x - y + 2^255.
            idx    <= '0;
            borrow <= 1'b0;
            state  <= limb_diff[LIMB] ? S_FIX : S_DONE;
          end else begin
            idx    <= idx + 1'b1;
            borrow <= limb_diff[LIMB];
          end
        end
        S_FIX: begin
          res_r[int'(idx)*LIMB +: LIMB] <= limb_diff[LIMB-1:0];
          if (last_limb) begin
            idx    <= '0;
            borrow <= 1'b0;
            state  <= S_DONE;
          end else begin
            idx    <= idx + 1'b1;
            borrow <= limb_diff[LIMB];
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign diff      = res_r;
  assign fsm_state = state;

endmodule

// File: doc/sub_modp_serial.md
# sub_modp_serial

Limb-serial modular subtractor for the field GF(p), p = 2^255 − 19. It computes diff = (x − y) mod p and is the inverse-direction companion to the combinational modular adder in the field-arithmetic datapath. It trades latency for area: one LIMB-bit subtract per clock through a ready/valid input port and a ready/valid output port.

## Interface

- N, 255: field element width in bits. Fixed to 255 for p = 2^255 − 19.
- LIMB, 51: bits processed per cycle. N % LIMB must be 0. K = N/LIMB limbs (5 at default).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock domain; this polarity and synchronicity are fixed.
- in_valid  in  1  x/y presented.
- in_ready  out  1  block can accept an operand pair.
- x  in  N  minuend. Must be canonical, 0 ≤ x ≤ p−1.
- y  in  N  subtrahend. Must be canonical, 0 ≤ y ≤ p−1.
- out_valid  out  1  diff holds a result.
- out_ready  in  1  consumer takes the result.
- diff  out  N  (x − y) mod p, canonical.

## Operation

- States: IDLE, SUB, FIX, DONE.
- IDLE
  - in_ready = 1 and out_valid = 0.
  - On in_valid & in_ready: latch x and y into internal registers, clear the limb index and borrow, go to SUB.
- SUB, one limb per cycle, index i = 0..K−1
  - {b, d_i} = x_i − y_i − borrow, at LIMB+1-bit width.
  - Write d_i into the result register at limb i and register b as the new borrow.
  - After limb K−1: final borrow 0 → DONE; final borrow 1 → FIX, with the limb index and borrow cleared.
- FIX, one limb per cycle
  - Applies only on negative difference. The result register holds x − y + 2^255; subtract 19 so the result equals x − y + p.
  - Limb 0 subtracts 19; higher limbs subtract 0 plus the borrow.
  - For canonical inputs the wrapped value is ≥ 20, so the final borrow is always 0.
  - After limb K−1 → DONE.
- DONE
  - out_valid = 1 and diff = result register.
  - On out_ready: → IDLE.
- Outputs and limbs
  - in_ready = 1 only in IDLE. There is no overlap between operations.
  - diff is driven directly from the result register at all times. It retains its last value after the output handshake until the next operation overwrites it limb by limb. Consumers may only sample diff while out_valid = 1.
  - Limb i means bits [i·LIMB + LIMB−1 : i·LIMB].
- Non-canonical inputs: not supported. The result is deterministic but is not guaranteed to be canonical or congruent.
- in_valid is ignored outside IDLE. x and y may change freely after the accepting edge.

## Timing

- Reset, asynchronous, active on rst_n = 0:
  - state = IDLE, limb index 0, borrow 0, x/y/result registers 0.
  - in_ready = 1, out_valid = 0, diff = 0.
  - Reset takes effect immediately, including mid-SUB, mid-FIX or in DONE; any partial result is discarded. The block is ready to accept on the first rising edge after rst_n deasserts.
- Accepting edge = A.
  - No correction: out_valid = 1 after edge A+K (A+5 at default).
  - Correction: out_valid = 1 after edge A+2K (A+10).
- Back-pressure: out_valid and diff are held stable for as long as out_ready = 0.
- Output handshake on edge H: out_valid = 0 and in_ready = 1 after H. Earliest next accept is edge H+1.
- Throughput: at best one result per K+2 cycles without correction, or 2K+2 cycles with correction.
- in_ready/out_valid are registered decodes of state. There are no combinational paths from in_valid or out_ready to any output.

## Test plan

- x=5, y=3 → diff=2; out_valid rises 5 edges after accept; FIX is never entered.
- x=3, y=5 → diff=p−2=2^255−21; out_valid rises 10 edges after accept. Also x=0, y=p−1 → diff=1.
- x=2^51, y=1 → diff=2^51−1, proving borrow propagates across the limb 0→1 boundary. x=y=p−1 → diff=0. x=p−1, y=0 → diff=p−1.
- Back-pressure: hold out_ready=0 for 3 cycles after out_valid. diff stays constant, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 for 1 cycle → in_ready=1 on the next cycle.
- Reset mid-operation: pull rst_n low during the 3rd SUB cycle of x=3, y=5. out_valid=0, in_ready=1 and diff=0 immediately. After release, a new op x=7, y=7 → diff=0.
- Random back-to-back canonical pairs (≥1000), with out_ready held high: each diff matches a (x−y) mod p model, and out_valid latency matches 5 or 10 edges by the sign of x−y.
